rc_sub_pipe_approx: RTL and testbench
=====================================

# rc_sub_pipe_approx

Pipelined approximate ripple-carry subtractor with a valid/ready handshake. It computes `Out = A - B` as `A + ~B + 1`, using the team's area/MSE-optimised approximate cell in the low `APPROX_BITS` positions and exact full adders above them. It is the subtraction counterpart to the approximate RC adder family. It sits between operand producers and error-tolerant datapath consumers that need registered, back-pressurable results.

## Interface
- `WIDTH`, default 8: operand width.
- `APPROX_BITS`, default 2: number of low bit positions built from approximate cells; legal range 0..`WIDTH`.
- `clk` input, 1: clock, rising edge.
- `rst_n` input, 1: reset; asynchronous, active-low.
- `in_valid` input, 1: operand pair valid.
- `in_ready` output, 1: stage 1 can accept.
- `in_a` input, `WIDTH`: minuend A.
- `in_b` input, `WIDTH`: subtrahend B.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts.
- `out_diff` output, `WIDTH+1`: bit `WIDTH` is carry-out (1 = no borrow); bits `WIDTH-1:0` are the difference.
- `stat_clr` input, 1: synchronous clear of the statistics counters.
- `err_sq_acc` output, 32: saturating sum of squared error.
- `sample_cnt` output, 16: saturating count of results.

## Operation
- Let `Yn = ~in_b`. Bit-0 carry-in is 1.
- For bit `i < APPROX_BITS`, the approximate cell is used, with `X = a[i]`, `Y = Yn[i]`, `Z = carry-in`:
  - `S = Z ^ (X & Y)`
  - `C = ~Z | (X & Y)`
- For bit `i >= APPROX_BITS`, the exact full adder is used: `S = X^Y^Z`, `C = maj(X,Y,Z)`.
- **Stage 1** registers:
  - the low `APPROX_BITS` difference bits,
  - the carry out of bit `APPROX_BITS-1` (1 when `APPROX_BITS = 0`),
  - `in_a[WIDTH-1:APPROX_BITS]`,
  - `Yn[WIDTH-1:APPROX_BITS]`.
- **Stage 2** computes the exact upper segment from the stage-1 registers and registers `out_diff`.
- All arithmetic is unsigned, modulo `2^WIDTH`, plus the carry bit. There is no signed interpretation.
- **Handshake:**
  - A transfer occurs on a cycle where `valid && ready`.
  - A stage may load when it is empty or when its contents leave downstream in the same cycle.
  - `in_ready = ~s1_valid | s2_can_load`, where `s2_can_load = ~out_valid | out_ready`.
  - While `out_valid = 1` and `out_ready = 0`, `out_diff` holds stable and is not modified.
- **Boundary conditions:**
  - `A = B`: approximate low bits can produce a nonzero result. This is required behaviour and must not be corrected.
  - `A < B`: carry-out is 0 and the low `WIDTH` bits wrap.
  - Simultaneous accept at the input and drain at the output with both stages full: the pipeline advances with no bubble.
  - `rst_n` asserted mid-operation: both stages are invalidated immediately and in-flight data is discarded.

## Timing
- Latency is 2 cycles from input transfer to `out_valid`.
- Throughput is 1 result per cycle when `out_ready = 1`.
- Reset values:
  - `in_ready = 1`
  - `out_valid = 0`
  - `out_diff = 0`
  - `err_sq_acc = 0`
  - `sample_cnt = 0`
- `in_ready` is combinational from `out_ready` and the internal valid flags. It has no dependence on `in_valid`.
- Statistics update on the clock edge following each output transfer (`out_valid && out_ready`).
- `stat_clr` has priority over an update in the same cycle.

## Configuration
- Macro: `RC_SUB_ERR_STAT_EN`.
- **Defined:**
  - An exact `WIDTH+1`-bit reference difference travels alongside each operand through the pipeline.
  - On each output transfer, `err = out_diff - exact`, interpreted as a signed value.
  - `err_sq_acc` increases by `err*err`, saturating at `32'hFFFF_FFFF`.
  - `sample_cnt` increments by 1, saturating at `16'hFFFF`.
- **Undefined:**
  - No reference path or counters are built.
  - `err_sq_acc` and `sample_cnt` are tied to 0.
  - `stat_clr` is ignored.
  - Port list is identical in both builds.

## Structure
- Package `rc_approx_pkg` contains:
  - the default-width constants,
  - the stat widths (32 and 16),
  - a `logic [1:0]` cell-result typedef `{carry, sum}`.
- Sub-module `approx_sub_cell` holds the approximate cell equations and is instantiated `APPROX_BITS` times.
- Exact bits use the existing `FullAdder`.

## Test plan
- **Reset and first result:**
  - Reset, then send A=100, B=37 with `out_ready = 1`.
  - `out_diff = 9'h141` (65) appears 2 cycles later.
  - With `RC_SUB_ERR_STAT_EN`: `err_sq_acc = 4`, `sample_cnt = 1`.
- **Equal operands:** A=0, B=0 → `out_diff = 9'h101` (exact would be `9'h100`); error +1.
- **All-ones minuend:** A=255, B=0 → `out_diff = 9'h1FC` (exact `9'h1FF`); error −3; `err_sq_acc` increases by 9.
- **Backpressure:**
  - Stream 4 operand pairs with `out_ready` held 0 for 5 cycles.
  - `in_ready` deasserts after 2 accepts.
  - `out_diff` is stable throughout.
  - After release, all 4 results drain in order on consecutive cycles.
- **Reset mid-operation:** assert `rst_n = 0` with both stages full → `out_valid = 0` immediately; no stale result after release.
- **Statistics clear and saturation:**
  - `stat_clr` pulsed in the same cycle as a transfer → counters read 0 afterwards.
  - Force `sample_cnt` to `16'hFFFF`, then transfer one result → it remains `16'hFFFF`.

Source files
------------

// File: rtl/rc_approx_pkg.sv
// rc_approx_pkg: shared constants and the approximate-cell result type
// for the approximate ripple-carry adder/subtractor family.
package rc_approx_pkg;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_BITS = 2;
    localparam int ERR_W           = 32;
    localparam int CNT_W           = 16;
    typedef logic [1:0] cell_t;  // {carry, sum}
endpackage

// File: rtl/FullAdder.sv
// FullAdder: exact one-bit full adder used above the approximate segment.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/approx_sub_cell.sv
// approx_sub_cell: area/MSE-optimised approximate adder cell; the sum ignores
// the propagate term and the carry is forced high whenever carry-in is low.
module approx_sub_cell
    import rc_approx_pkg::*;
(
    input  logic  x,
    input  logic  y,
    input  logic  z,
    output cell_t res
);
    logic g;
    assign g   = x & y;
    assign res = {~z | g, z ^ g};
endmodule

// File: rtl/rc_sub_pipe_approx.sv
// rc_sub_pipe_approx: two-stage approximate ripple-carry subtractor (A + ~B + 1)
// with valid/ready handshake; error statistics built only with RC_SUB_ERR_STAT_EN.
module rc_sub_pipe_approx
    import rc_approx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_diff,
    input  logic             stat_clr,
    output logic [ERR_W-1:0] err_sq_acc,
    output logic [CNT_W-1:0] sample_cnt
);
    localparam int AB = APPROX_BITS;
    localparam int HW = WIDTH - AB;
    localparam int PW = 2 * HW + AB + 1;

    // Stage-1 payload layout: {yn_hi, a_hi, carry, low_diff}
    logic [WIDTH-1:0] yn;
    logic [AB:0]      c1;
    logic [WIDTH:AB]  c2;
    logic [PW-1:0]    p1, s1;
    logic [WIDTH:0]   d2;
    logic             s1_valid, s2_can_load, s1_load;

    assign yn          = ~in_b;
    assign c1[0]       = 1'b1;
    assign p1[AB]      = c1[AB];
    assign c2[AB]      = s1[AB];
    assign d2[WIDTH]   = c2[WIDTH];
    assign s2_can_load = ~out_valid | out_ready;
    assign in_ready    = ~s1_valid | s2_can_load;
    assign s1_load     = in_valid & in_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < AB) begin : g_apx
            cell_t r;
            approx_sub_cell u_cell (.x(in_a[i]), .y(yn[i]), .z(c1[i]), .res(r));
            assign c1[i+1] = r[1];
            assign p1[i]   = r[0];
            assign d2[i]   = s1[i];
        end else begin : g_ex
            assign p1[i+1]      = in_a[i];
            assign p1[i+1+HW]   = yn[i];
            FullAdder u_fa (.a(s1[i+1]), .b(s1[i+1+HW]), .cin(c2[i]), .s(d2[i]), .cout(c2[i+1]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            out_diff  <= '0;
        end else begin
            if (s1_load) s1 <= p1;
            if (s1_load | s2_can_load) s1_valid <= s1_load;
            if (s2_can_load) begin
                out_valid <= s1_valid;
                if (s1_valid) out_diff <= d2;
            end
        end
    end

`ifdef RC_SUB_ERR_STAT_EN
    logic [WIDTH:0]          ref1, s1_ref, out_ref;
    logic signed [WIDTH+1:0] err;
    logic signed [63:0]      e64;
    logic [63:0]             sq, sum;
    logic [ERR_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;

    assign ref1       = {1'b0, in_a} + {1'b0, yn} + (WIDTH+1)'(1);
    assign err        = $signed({1'b0, out_diff}) - $signed({1'b0, out_ref});
    assign e64        = 64'(err);
    assign sq         = e64 * e64;
    assign sum        = sq + {32'b0, acc};
    assign err_sq_acc = acc;
    assign sample_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ref  <= '0;
            out_ref <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            if (s1_load) s1_ref <= ref1;
            if (s2_can_load && s1_valid) out_ref <= s1_ref;
            if (stat_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (out_valid && out_ready) begin
                acc <= |sum[63:ERR_W] ? '1 : sum[ERR_W-1:0];
                cnt <= &cnt ? cnt : cnt + 1'b1;
            end
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign err_sq_acc      = '0;
    assign sample_cnt      = '0;
`endif
endmodule

// File: tb/tb_rc_sub_pipe_approx.sv
// tb_rc_sub_pipe_approx: directed stimulus against a queue-based behavioural model.
module tb_rc_sub_pipe_approx;
    localparam int W  = 8;
    localparam int AB = 2;
`ifdef RC_SUB_ERR_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, stat_clr = 0;
    logic [W-1:0] in_a = 0, in_b = 0;
    logic         in_ready, out_valid;
    logic [W:0]   out_diff;
    logic [31:0]  err_sq_acc;
    logic [15:0]  sample_cnt;

    always #5 clk = ~clk;

    rc_sub_pipe_approx #(.WIDTH(W), .APPROX_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_diff(out_diff), .stat_clr(stat_clr), .err_sq_acc(err_sq_acc),
        .sample_cnt(sample_cnt)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [8:0] apx(input logic [7:0] a, input logic [7:0] b);
        logic       c, g;
        logic [7:0] nb;
        int         lo, hi;
        c  = 1'b1;
        lo = 0;
        nb = ~b;
        for (int i = 0; i < AB; i++) begin
            g  = a[i] & nb[i];
            lo = lo | (int'(c ^ g) << i);
            c  = ~c | g;
        end
        hi = int'(a >> AB) + int'(nb >> AB) + int'(c);
        return 9'((hi << AB) | lo);
    endfunction

    function automatic logic [8:0] exact(input logic [7:0] a, input logic [7:0] b);
        return 9'(256 + int'(a) - int'(b));
    endfunction

    typedef struct {
        logic [8:0] ap;
        logic [8:0] ex;
    } item_t;
    item_t  q[$];
    longint macc = 0;
    int     mcnt = 0;

    // Model observes the upcoming edge at each negedge, after checking the current state.
    always @(negedge clk) begin : model
        int e;
        if (!rst_n) begin
            q.delete();
            macc = 0;
            mcnt = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_diff", out_diff, 0);
            chk("rst_err_sq", err_sq_acc, 0);
            chk("rst_cnt", sample_cnt, 0);
        end else begin
            if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else if (out_valid) chk("out_diff", out_diff, q[0].ap);
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            chk("err_sq_acc", err_sq_acc, macc);
            chk("sample_cnt", sample_cnt, mcnt);
            if (STAT && stat_clr) begin
                macc = 0;
                mcnt = 0;
            end else if (STAT && out_valid && out_ready && q.size() > 0) begin
                e    = int'(q[0].ap) - int'(q[0].ex);
                macc = macc + e * e;
                if (macc > 64'hFFFF_FFFF) macc = 64'hFFFF_FFFF;
                if (mcnt < 65535) mcnt++;
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back('{apx(in_a, in_b), exact(in_a, in_b)});
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 50);
        chk("send_accept", ok, 1);
        #1 in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] va[4] = '{8'd11, 8'd200, 8'd5, 8'd99};
    logic [7:0] vb[4] = '{8'd3, 8'd100, 8'd9, 8'd99};
    logic [7:0] da[6] = '{8'd10, 8'd200, 8'd3, 8'd128, 8'd77, 8'd0};
    logic [7:0] db[6] = '{8'd20, 8'd1, 8'd3, 8'd129, 8'd77, 8'd255};

    initial begin : watchdog
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        int idx, outs, first, last;
        bit tr_in, tr_out;
        logic [8:0] held;

        chk("model_100_37", apx(100, 37), 9'h141);
        chk("model_0_0", apx(0, 0), 9'h101);
        chk("model_255_0", apx(255, 0), 9'h1FC);
        chk("exact_255_0", exact(255, 0), 9'h1FF);
        chk("model_10_20", apx(10, 20), 9'h0F7);

        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;

        send(100, 37);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("first_diff", out_diff, 9'h141);
        @(negedge clk);
`ifdef RC_SUB_ERR_STAT_EN
        chk("first_err_sq", err_sq_acc, 4);
        chk("first_cnt", sample_cnt, 1);
`else
        chk("first_err_sq_off", err_sq_acc, 0);
        chk("first_cnt_off", sample_cnt, 0);
`endif
        send(0, 0);
        send(255, 0);
        idle(4);
`ifdef RC_SUB_ERR_STAT_EN
        chk("three_err_sq", err_sq_acc, 14);
        chk("three_cnt", sample_cnt, 3);
`else
        chk("three_err_sq_off", err_sq_acc, 0);
`endif

        for (int i = 0; i < 6; i++) send(da[i], db[i]);
        idle(4);

        // Backpressure: out_ready low for five cycles while streaming four pairs.
        out_ready = 0;
        idx = 0; outs = 0; first = -1; last = -1; held = '0;
        in_a = va[0]; in_b = vb[0]; in_valid = 1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) out_ready = 1;
            @(negedge clk);
            tr_in  = in_valid && in_ready;
            tr_out = out_valid && out_ready;
            if (c == 2) held = out_diff;
            if (c == 4) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_hold", out_diff, held);
                chk("bp_accepts", idx, 2);
            end
            if (tr_out) begin
                outs++;
                if (first < 0) first = c;
                last = c;
            end
            @(posedge clk);
            #1;
            if (tr_in) begin
                idx++;
                if (idx < 4) begin
                    in_a = va[idx];
                    in_b = vb[idx];
                end else in_valid = 0;
            end
        end
        chk("bp_outs", outs, 4);
        chk("bp_consecutive", last - first, 3);

        // Reset with both stages full.
        out_ready = 0;
        send(1, 2);
        send(3, 4);
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ready", in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        #2 rst_n = 1;
        out_ready = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Statistics clear coinciding with a transfer.
        send(255, 0);
        idle(3);
`ifdef RC_SUB_ERR_STAT_EN
        chk("pre_clr_cnt", sample_cnt, 1);
`endif
        send(50, 40);
        stat_clr = 1;
        @(posedge clk);
        @(posedge clk);
        #1 stat_clr = 0;
        @(negedge clk);
        chk("clr_err_sq", err_sq_acc, 0);
        chk("clr_cnt", sample_cnt, 0);

`ifdef RC_SUB_ERR_STAT_EN
        in_a = 0; in_b = 0; in_valid = 1;
        repeat (65540) @(posedge clk);
        #1 in_valid = 0;
        idle(4);
        chk("sat_cnt", sample_cnt, 16'hFFFF);
        send(255, 0);
        idle(4);
        chk("sat_cnt_hold", sample_cnt, 16'hFFFF);
`endif

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
